lcd_bus_driver: RTL and testbench

//  Write-only HD44780 bus timing engine downstream of the LCD custom-instruction block.

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_timer.sv | 35 +++
 rtl/lcd_bus_driver.sv | 141 ++++++++++++++
 tb/tb_lcd_bus_driver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only bus driver.
// Optional power-on wait (macro LCD_POWERON_WAIT_EN) is handled in lcd_bus_driver.
package lcd_pkg;

    // Bus sequencing states; PWRON is only reachable when the power-on wait is built in.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC,
        PWRON
    } lcd_state_e;

    // Default timing in clock cycles for a 50 MHz clock.
    localparam int unsigned LCD_SETUP_CYC_DEF     = 2;       // 40 ns address setup
    localparam int unsigned LCD_PULSE_CYC_DEF     = 12;      // 240 ns enable pulse
    localparam int unsigned LCD_HOLD_CYC_DEF      = 2;       // 40 ns data hold
    localparam int unsigned LCD_EXEC_CYC_DEF      = 2000;    // 40 us normal execution
    localparam int unsigned LCD_LONG_EXEC_CYC_DEF = 80000;   // 1.6 ms clear / home
    localparam int unsigned LCD_POWERON_CYC_DEF   = 750000;  // 15 ms after power-up

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter used to time every phase of the LCD bus cycle.
// The count is loaded on phase entry and the phase ends when it reaches 1;
// it saturates at 1 so it can never wrap while the driver is idle.
module lcd_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    output logic             last_o,
    output logic             last_next_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load takes priority, otherwise count down towards 1.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register; it is always loaded before a phase relies on it.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign last_o      = (count_q == CNT_W'(1));
    assign last_next_o = (count_d == CNT_W'(1));

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 write-only bus timing engine. Takes one byte per valid/ready command,
// drives RS/DB with setup, EN pulse and hold, waits out the execution time and
// pulses done in the final wait cycle.
// Define LCD_POWERON_WAIT_EN to hold the driver in a power-on wait after every reset.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = LCD_SETUP_CYC_DEF,
    parameter int unsigned PULSE_CYC     = LCD_PULSE_CYC_DEF,
    parameter int unsigned HOLD_CYC      = LCD_HOLD_CYC_DEF,
    parameter int unsigned EXEC_CYC      = LCD_EXEC_CYC_DEF,
    parameter int unsigned LONG_EXEC_CYC = LCD_LONG_EXEC_CYC_DEF,
    parameter int unsigned POWERON_CYC   = LCD_POWERON_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                           max2(LONG_EXEC_CYC, POWERON_CYC));
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    lcd_state_e       state_q, state_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             lcd_en_q, lcd_en_d;
    logic             done_q, done_d;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_last;
    logic             timer_last_next;

    lcd_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk          (clk),
        .load_i       (timer_load),
        .load_value_i (timer_value),
        .last_o       (timer_last),
        .last_next_o  (timer_last_next)
    );

    // Next state, captured command and timer load for each phase entry.
    always_comb begin
        state_d     = state_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;
        timer_load  = 1'b0;
        timer_value = CNT_W'(SETUP_CYC);
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d     = SETUP;
                    lcd_rs_d    = cmd_rs;
                    lcd_data_d  = cmd_data;
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(SETUP_CYC);
                end
            end
            SETUP: begin
                if (timer_last) begin
                    state_d     = PULSE;
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(PULSE_CYC);
                end
            end
            PULSE: begin
                if (timer_last) begin
                    state_d     = HOLD;
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(HOLD_CYC);
                end
            end
            HOLD: begin
                if (timer_last) begin
                    state_d     = EXEC;
                    timer_load  = 1'b1;
                    // The latched byte is still on the bus, so classify it from there.
                    timer_value = is_long_cmd(lcd_rs_q, lcd_data_q) ? CNT_W'(LONG_EXEC_CYC)
                                                                    : CNT_W'(EXEC_CYC);
                end
            end
            EXEC: begin
                if (timer_last) begin
                    state_d = IDLE;
                end
            end
            PWRON: begin
                if (timer_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            lcd_rs_d   = 1'b0;
            lcd_data_d = 8'h00;
`ifdef LCD_POWERON_WAIT_EN
            state_d     = PWRON;
            timer_load  = 1'b1;
            timer_value = CNT_W'(POWERON_CYC);
`else
            state_d     = IDLE;
`endif
        end
    end

    // Registered pin values derived from the state being entered.
    always_comb begin
        lcd_en_d = (state_d == PULSE);
        done_d   = (state_d == EXEC) && timer_last_next;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        state_q    <= state_d;
        lcd_rs_q   <= lcd_rs_d;
        lcd_data_q <= lcd_data_d;
        lcd_en_q   <= lcd_en_d;
        done_q     <= done_d;
    end

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign done      = done_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_en    = lcd_en_q;
    assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Self-checking bench for lcd_bus_driver: directed command table, multi-cycle
// corner sequences and a randomized run against a cycle-arithmetic reference.
// Build with LCD_POWERON_WAIT_EN defined to exercise the power-on wait.
module tb_lcd_bus_driver;

    localparam int S  = 2;
    localparam int P  = 3;
    localparam int H  = 2;
    localparam int E  = 5;
    localparam int L  = 20;
    localparam int PW = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rs = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready;
    logic       done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    always #5 clk = ~clk;

    lcd_bus_driver #(
        .SETUP_CYC     (S),
        .PULSE_CYC     (P),
        .HOLD_CYC      (H),
        .EXEC_CYC      (E),
        .LONG_EXEC_CYC (L),
        .POWERON_CYC   (PW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .done      (done),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: last accepted command expressed as cycle numbers.
    int         ka       = -1000;  // cycle in which the last command was accepted
    int         wl       = E;      // its execution wait
    int         pw_until = -1000;  // last cycle of the power-on wait
    logic       m_rs     = 1'b0;
    logic [7:0] m_data   = 8'h00;

    logic obs_ready, obs_done, obs_en;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         done_off;
        int         ready_off;
    } vec_t;

    vec_t tbl[9];

    function automatic int exec_len(input logic rs, input logic [7:0] d);
        if (rs == 1'b0 && (d == 8'd1 || d == 8'd2 || d == 8'd3)) return L;
        return E;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input logic r, input logic v, input logic rs, input logic [7:0] d);
        logic        e_ready, e_en, e_done;
        logic [12:0] act, expv;
        int          t;
        @(posedge clk);
        cyc++;
        t = cyc;
        #1;
        reset = r; cmd_valid = v; cmd_rs = rs; cmd_data = d;
        #1;
        e_ready = !r && (t > ka + S + P + H + wl) && (t > pw_until);
        e_en    = (t >= ka + 1 + S) && (t <= ka + S + P);
        e_done  = (t == ka + S + P + H + wl);
        act  = {cmd_ready, lcd_en, done, lcd_rs, lcd_rw, lcd_data};
        expv = {e_ready, e_en, e_done, m_rs, 1'b0, m_data};
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL cycle_outputs cyc=%0d got=%b want=%b (ready,en,done,rs,rw,data)", t, act, expv);
        end
        obs_ready = cmd_ready;
        obs_done  = done;
        obs_en    = lcd_en;
        if (r) begin
            ka = -1000; m_rs = 1'b0; m_data = 8'h00;
`ifdef LCD_POWERON_WAIT_EN
            pw_until = t + PW;
`endif
        end else if (v && e_ready) begin
            ka = t; m_rs = rs; m_data = d; wl = exec_len(rs, d);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        while (!obs_ready && n < 60) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            n++;
        end
        if (!obs_ready) check("idle_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, done_at, ready_at, low, dcnt;
        int acc[$];

        tbl[0] = '{1'b1, 8'h41, 12, 13};
        tbl[1] = '{1'b0, 8'h01, 27, 28};
        tbl[2] = '{1'b0, 8'h02, 27, 28};
        tbl[3] = '{1'b0, 8'h03, 27, 28};
        tbl[4] = '{1'b0, 8'h04, 12, 13};
        tbl[5] = '{1'b1, 8'h01, 12, 13};
        tbl[6] = '{1'b0, 8'h00, 12, 13};
        tbl[7] = '{1'b0, 8'h81, 12, 13};
        tbl[8] = '{1'b1, 8'h02, 12, 13};

        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("reset_ready", int'(obs_ready), 0);
        check("reset_en", int'(obs_en), 0);

`ifdef LCD_POWERON_WAIT_EN
        low = 0;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        while (!obs_ready && low < 40) begin
            low++;
            step(1'b0, 1'b0, 1'b0, 8'h00);
        end
        check("poweron_low_cycles", low, PW);
`else
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("ready_after_reset", int'(obs_ready), 1);
`endif

        // Directed command table: done and ready offsets from the accepting cycle.
        for (int i = 0; i < 9; i++) begin
            wait_idle();
            step(1'b0, 1'b1, tbl[i].rs, tbl[i].d);
            k = cyc;
            check("accept", int'(obs_ready), 1);
            done_at = -1; ready_at = -1;
            for (int n = 0; n < 40 && ready_at < 0; n++) begin
                step(1'b0, 1'b0, 1'b0, 8'h00);
                if (obs_done && done_at < 0) done_at = cyc - k;
                if (obs_ready) ready_at = cyc - k;
            end
            check($sformatf("done_off[%0d]", i), done_at, tbl[i].done_off);
            check($sformatf("ready_off[%0d]", i), ready_at, tbl[i].ready_off);
        end

        // Valid held high with changing data: back-to-back accepts with no bubble.
        wait_idle();
        for (int n = 0; n < 40; n++) begin
            step(1'b0, 1'b1, 1'b1, 8'($urandom));
            if (obs_ready) acc.push_back(cyc);
        end
        if (acc.size() >= 3) begin
            check("b2b_gap0", acc[1] - acc[0], S + P + H + E + 1);
            check("b2b_gap1", acc[2] - acc[1], S + P + H + E + 1);
        end else begin
            check("b2b_accepts", acc.size(), 3);
        end

        // Reset in the middle of the enable pulse.
        wait_idle();
        step(1'b0, 1'b1, 1'b0, 8'h55);
        k = cyc;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("en_in_pulse", int'(obs_en), 1);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("en_after_reset", int'(obs_en), 0);
`ifdef LCD_POWERON_WAIT_EN
        low = 0;
        while (!obs_ready && low < 40) begin
            low++;
            step(1'b0, 1'b0, 1'b0, 8'h00);
        end
        check("poweron_low_after_midreset", low, PW);
`else
        check("ready_after_midreset", int'(obs_ready), 1);
`endif
        dcnt = 0;
        for (int n = 0; n < 30; n++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00);
            if (obs_done) dcnt++;
        end
        check("no_done_after_reset", dcnt, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic       r, v, rs;
            logic [7:0] d;
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 2) != 0);
            rs = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            step(r, v, rs, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
